video_out_reader: RTL and testbench

VIDEO_OUT_READER -- requirements
Module: video_out_reader

---
 rtl/video_out_reader.sv | 253 +++++++++++++++++++++++++
 tb/tb_video_out_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_out_reader.sv
// Wishbone frame-buffer reader feeding a raster pixel stream through a 2 x 8-word ping-pong buffer.
// Define VIDEO_OUT_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module video_out_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h40005000,
    parameter int          H_ACTIVE  = 640,
    parameter int          H_TOTAL   = 800,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_TOTAL   = 525
) (
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic        pixel_en,
    input  logic        start,
    output logic        frame_valid,
    output logic        line_valid,
    output logic [7:0]  pixel_out,
    output logic        underrun,
    output logic [31:0] p_wb_ADR_O,
    input  logic [31:0] p_wb_DAT_I,
    output logic [31:0] p_wb_DAT_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic        p_wb_LOCK_O,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I,
    input  logic        p_wb_RTY_I
`ifdef VIDEO_OUT_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    localparam int          H_W         = $clog2(H_TOTAL);
    localparam int          V_W         = $clog2(V_TOTAL);
    localparam logic [31:0] FRAME_BYTES = 32'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [31:0]  off_q, off_d;
    logic [31:0]  off_next;
    logic [31:0]  adr_q, adr_d;
    logic         cyc_q, cyc_d;
    logic         stb_q, stb_d;
    logic         fill_half_q, fill_half_d;
    logic [2:0]   fill_word_q, fill_word_d;
    logic [31:0]  buf_q [16];
    logic [31:0]  buf_d [16];
    logic [1:0]   full_q, full_d;
    logic [1:0]   set_full, clr_full;
    logic         running_q, running_d;

    logic           timing_q, timing_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           frame_valid_q, frame_valid_d;
    logic           line_valid_q, line_valid_d;
    logic [7:0]     pixel_q, pixel_d;
    logic           underrun_q, underrun_d;
    logic           cons_half_q, cons_half_d;
    logic [4:0]     cons_idx_q, cons_idx_d;
    logic [31:0]    cur_word;
    logic           slot_fv, slot_lv;
    logic           underrun_pixel;

    // Byte offset into the frame; wraps so the frame is re-read from BASE_ADDR.
    assign off_next = (off_q + 32'd4 == FRAME_BYTES) ? 32'd0 : off_q + 32'd4;

    // Fetch FSM: bus outputs are registered, so CYC/STB are high only in WAIT_ACK.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        adr_d       = adr_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        fill_half_d = fill_half_q;
        fill_word_d = fill_word_q;
        buf_d       = buf_q;
        set_full    = 2'b00;
        running_d   = running_q | start;
        case (state_q)
            IDLE: begin
                if ((running_q || start) && !full_q[fill_half_q]) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                adr_d   = BASE_ADDR + off_q;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (p_wb_ACK_I || p_wb_ERR_I) begin
                    buf_d[{fill_half_q, fill_word_q}] = p_wb_ACK_I ? p_wb_DAT_I : 32'd0;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    off_d       = off_next;
                    fill_word_d = fill_word_q + 3'd1;
                    if (fill_word_q == 3'd7) begin
                        set_full[fill_half_q] = 1'b1;
                        fill_half_d           = ~fill_half_q;
                        state_d               = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end else if (p_wb_RTY_I) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_word = buf_q[{cons_half_q, cons_idx_q[4:2]}];
    assign slot_fv  = (v_q < V_W'(V_ACTIVE));
    assign slot_lv  = slot_fv && (h_q < H_W'(H_ACTIVE));

    // Raster timer and pixel consumer; everything advances only on pixel_en once timing starts.
    always_comb begin
        timing_d       = timing_q;
        h_d            = h_q;
        v_d            = v_q;
        frame_valid_d  = frame_valid_q;
        line_valid_d   = line_valid_q;
        pixel_d        = pixel_q;
        underrun_d     = underrun_q;
        cons_half_d    = cons_half_q;
        cons_idx_d     = cons_idx_q;
        clr_full       = 2'b00;
        underrun_pixel = 1'b0;
        if (!timing_q) begin
            if (running_q && (&full_q)) begin
                timing_d = 1'b1;
            end
        end else if (pixel_en) begin
            frame_valid_d = slot_fv;
            line_valid_d  = slot_lv;
            pixel_d       = 8'd0;
            if (slot_lv) begin
                if (full_q[cons_half_q]) begin
                    pixel_d = cur_word[{cons_idx_q[1:0], 3'b000} +: 8];
                end else begin
                    underrun_d     = 1'b1;
                    underrun_pixel = 1'b1;
                end
                cons_idx_d = cons_idx_q + 5'd1;
                if (cons_idx_q == 5'd31) begin
                    clr_full[cons_half_q] = 1'b1;
                    cons_half_d           = ~cons_half_q;
                end
            end
            if (h_q == H_W'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + V_W'(1);
            end else begin
                h_d = h_q + H_W'(1);
            end
        end
    end

    // Set wins over clear: a starved half being filled as it is skipped must keep its new data.
    assign full_d = (full_q & ~clr_full) | set_full;

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q       <= IDLE;
            off_q         <= '0;
            adr_q         <= '0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            fill_half_q   <= 1'b0;
            fill_word_q   <= '0;
            buf_q         <= '{default: '0};
            full_q        <= '0;
            running_q     <= 1'b0;
            timing_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            frame_valid_q <= 1'b0;
            line_valid_q  <= 1'b0;
            pixel_q       <= '0;
            underrun_q    <= 1'b0;
            cons_half_q   <= 1'b0;
            cons_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            adr_q         <= adr_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            fill_half_q   <= fill_half_d;
            fill_word_q   <= fill_word_d;
            buf_q         <= buf_d;
            full_q        <= full_d;
            running_q     <= running_d;
            timing_q      <= timing_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_valid_q <= frame_valid_d;
            line_valid_q  <= line_valid_d;
            pixel_q       <= pixel_d;
            underrun_q    <= underrun_d;
            cons_half_q   <= cons_half_d;
            cons_idx_q    <= cons_idx_d;
        end
    end

`ifdef VIDEO_OUT_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_pixel && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`else
    logic unused_underrun_pixel;
    assign unused_underrun_pixel = underrun_pixel;
`endif

    assign frame_valid = frame_valid_q;
    assign line_valid  = line_valid_q;
    assign pixel_out   = pixel_q;
    assign underrun    = underrun_q;
    assign p_wb_ADR_O  = adr_q;
    assign p_wb_DAT_O  = 32'd0;
    assign p_wb_CYC_O  = cyc_q;
    assign p_wb_STB_O  = stb_q;
    assign p_wb_WE_O   = 1'b0;
    assign p_wb_SEL_O  = 4'hF;
    assign p_wb_LOCK_O = 1'b0;

endmodule

// File: tb/tb_video_out_reader.sv
// Scoreboard bench for video_out_reader on a reduced 48x6 (64x8 total) raster with a random Wishbone slave.
// Honours VIDEO_OUT_UNDERRUN_CNT_EN when the design is built with it.
module tb_video_out_reader;

    localparam logic [31:0] BASE        = 32'h40005000;
    localparam int          HA          = 48;
    localparam int          HT          = 64;
    localparam int          VA          = 6;
    localparam int          VT          = 8;
    localparam int          FRAME_BYTES = HA * VA;
    localparam int          FRAME_WORDS = FRAME_BYTES / 4;
    localparam int          FRAME_CYC   = HT * VT * 4;

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        pixel_en = 1'b0;
    logic        start = 1'b0;
    logic        frame_valid, line_valid, underrun;
    logic [7:0]  pixel_out;
    logic [31:0] p_wb_ADR_O, p_wb_DAT_O;
    logic [31:0] p_wb_DAT_I = '0;
    logic        p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_ACK_I = 1'b0;
    logic        p_wb_ERR_I = 1'b0;
    logic        p_wb_RTY_I = 1'b0;
`ifdef VIDEO_OUT_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    video_out_reader #(
        .BASE_ADDR(BASE), .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .p_clk(p_clk), .p_resetn(p_resetn), .pixel_en(pixel_en), .start(start),
        .frame_valid(frame_valid), .line_valid(line_valid), .pixel_out(pixel_out),
        .underrun(underrun), .p_wb_ADR_O(p_wb_ADR_O), .p_wb_DAT_I(p_wb_DAT_I),
        .p_wb_DAT_O(p_wb_DAT_O), .p_wb_CYC_O(p_wb_CYC_O), .p_wb_STB_O(p_wb_STB_O),
        .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O), .p_wb_LOCK_O(p_wb_LOCK_O),
        .p_wb_ACK_I(p_wb_ACK_I), .p_wb_ERR_I(p_wb_ERR_I), .p_wb_RTY_I(p_wb_RTY_I)
`ifdef VIDEO_OUT_UNDERRUN_CNT_EN
        , .underrun_count(underrun_count)
`endif
    );

    always #5 p_clk = ~p_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem [FRAME_WORDS];
    logic [7:0]  exp_pix [$];
    int          exp_off = 0;
    int          words_served = 0;
    bit          slave_busy = 0;
    int          slave_delay = 0;
    bit          stall_req = 0;
    bit          anchored = 0;
    bit          pix_chk = 1;
    int          slot = 0;
    int          pe_cnt = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // pixel_en every 4th cycle, driven away from the sampling edge
    always @(negedge p_clk) begin
        pe_cnt++;
        pixel_en = (pe_cnt % 4 == 0);
    end

    // Wishbone slave + stimulus side of the scoreboard: every served word queues its 4 bytes LSB first.
    always begin
        int r;
        logic [31:0] word;
        @(posedge p_clk);
        #1;
        p_wb_ACK_I = 1'b0;
        p_wb_ERR_I = 1'b0;
        p_wb_RTY_I = 1'b0;
        if (!p_resetn || !(p_wb_CYC_O && p_wb_STB_O)) begin
            slave_busy = 0;
        end else begin
            if (!slave_busy) begin
                slave_busy = 1;
                check_output("read_addr", p_wb_ADR_O, BASE + 32'(exp_off));
                slave_delay = stall_req ? 2000 : int'($urandom_range(0, 3));
                stall_req = 0;
            end
            if (slave_delay > 0) begin
                slave_delay--;
            end else begin
                r = int'($urandom_range(0, 99));
                if (words_served >= 4 && r < 5) begin
                    p_wb_RTY_I = 1'b1;
                end else begin
                    if (words_served >= 4 && r < 10) begin
                        p_wb_ERR_I = 1'b1;
                        word = 32'd0;
                    end else begin
                        p_wb_ACK_I = 1'b1;
                        word = mem[exp_off / 4];
                        p_wb_DAT_I = word;
                    end
                    for (int b = 0; b < 4; b++) exp_pix.push_back(word[8*b +: 8]);
                    exp_off = (exp_off + 4) % FRAME_BYTES;
                    words_served++;
                end
                slave_busy = 0;
            end
        end
    end

    // Monitor: raster position is slot arithmetic from the first frame_valid slot; pixels pop the queue.
    always begin
        bit pe;
        bit rst_ok;
        int h, v;
        bit efv, elv;
        @(posedge p_clk);
        pe = pixel_en;
        rst_ok = p_resetn;
        #1;
        if (pe && rst_ok && p_resetn) begin
            if (!anchored) begin
                if (frame_valid) begin
                    anchored = 1;
                    slot = 0;
                    check_output("both_halves_before_start", 32'(words_served >= 16), 32'd1);
                end else begin
                    check_output("pre_start_line_valid", 32'(line_valid), 32'd0);
                end
            end
            if (anchored) begin
                h = slot % HT;
                v = (slot / HT) % VT;
                efv = (v < VA);
                elv = efv && (h < HA);
                check_output("frame_valid", 32'(frame_valid), 32'(efv));
                check_output("line_valid", 32'(line_valid), 32'(elv));
                if (!elv) begin
                    check_output("blank_pixel", 32'(pixel_out), 32'd0);
                end else if (pix_chk) begin
                    n_cmp++;
                    if (exp_pix.size() == 0) begin
                        n_bad++;
                        $display("[TB] FAIL pixel: got %0h expected none queued at %0t", pixel_out, $time);
                    end else if (pixel_out !== exp_pix[0]) begin
                        n_bad++;
                        $display("[TB] FAIL pixel: got %0h expected %0h at %0t", pixel_out, exp_pix[0], $time);
                        void'(exp_pix.pop_front());
                    end else begin
                        void'(exp_pix.pop_front());
                    end
                end
                slot++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        check_output({tag, "_line_valid"}, 32'(line_valid), 32'd0);
        check_output({tag, "_pixel_out"}, 32'(pixel_out), 32'd0);
        check_output({tag, "_underrun"}, 32'(underrun), 32'd0);
        check_output({tag, "_adr"}, p_wb_ADR_O, 32'd0);
        check_output({tag, "_cyc"}, 32'(p_wb_CYC_O), 32'd0);
        check_output({tag, "_stb"}, 32'(p_wb_STB_O), 32'd0);
        check_output({tag, "_we"}, 32'(p_wb_WE_O), 32'd0);
        check_output({tag, "_sel"}, 32'(p_wb_SEL_O), 32'hF);
        check_output({tag, "_lock"}, 32'(p_wb_LOCK_O), 32'd0);
        check_output({tag, "_dat_o"}, p_wb_DAT_O, 32'd0);
`ifdef VIDEO_OUT_UNDERRUN_CNT_EN
        check_output({tag, "_underrun_count"}, 32'(underrun_count), 32'd0);
`endif
    endtask

    task automatic hold_reset_and_flush();
        repeat (3) @(negedge p_clk);
        exp_pix.delete();
        exp_off = 0;
        words_served = 0;
        anchored = 0;
        p_resetn = 1'b1;
    endtask

    task automatic apply_stimulus(input int cycles);
        @(negedge p_clk);
        start = 1'b1;
        @(negedge p_clk);
        start = 1'b0;
        repeat (cycles) @(negedge p_clk);
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < FRAME_WORDS; k++) mem[k] = (k < 4) ? 32'(k) : $urandom;

        #1;
        check_reset_outputs("por");
        hold_reset_and_flush();

        // Random responses across three frames, several address wraps, a stray start mid-run
        apply_stimulus(FRAME_CYC + FRAME_CYC / 2);
        apply_stimulus(FRAME_CYC + FRAME_CYC / 2);
        check_output("timer_started", 32'(anchored), 32'd1);
        check_output("address_wrapped", 32'(words_served > FRAME_WORDS), 32'd1);
        check_output("no_underrun", 32'(underrun), 32'd0);

        // Reset while a read is outstanding
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge p_clk);
            seen = p_wb_CYC_O && p_wb_STB_O;
        end
        check_output("cyc_seen_before_reset", 32'(seen), 32'd1);
        p_resetn = 1'b0;
        #1;
        check_reset_outputs("midcycle");
        hold_reset_and_flush();
        apply_stimulus(FRAME_CYC + FRAME_CYC / 2);
        check_output("restart_timer", 32'(anchored), 32'd1);
        check_output("restart_no_underrun", 32'(underrun), 32'd0);

        // Starve the reader with a 2000-cycle ACK stall; raster timing must stay intact
        pix_chk = 0;
        stall_req = 1;
        repeat (2200 + FRAME_CYC) @(negedge p_clk);
        check_output("underrun_sticky", 32'(underrun), 32'd1);
`ifdef VIDEO_OUT_UNDERRUN_CNT_EN
        check_output("underrun_count_nonzero", 32'(underrun_count != 16'd0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
